// File: rtl/ttl_shift_pkg.sv
// Mode encodings shared by the universal shift-register parts (74194, 74198, 74299).
package ttl_shift_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD        = 2'b00,
    MODE_SHIFT_RIGHT = 2'b01,
    MODE_SHIFT_LEFT  = 2'b10,
    MODE_LOAD        = 2'b11
  } shift_mode_e;

endpackage

// File: rtl/ttl_74198.sv
// WIDTH-bit universal shift register (hold/shift-right/shift-left/load), async active-low clear.
// Zero added latency: Q updates at the Clk edge; no backpressure. Optional Clk_inhibit via TTL_74198_CLK_INHIBIT_EN.
module ttl_74198
  import ttl_shift_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DELAY_RISE = 0,
  parameter int DELAY_FALL = 0
) (
  input  logic             Clk,
`ifdef TTL_74198_CLK_INHIBIT_EN
  input  logic             Clk_inhibit,
`endif
  input  logic             Clear_bar,
  input  logic [1:0]       S,
  input  logic             DSR,
  input  logic             DSL,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] q_current;

  // Rise/fall delays are a board-level timing model only; the hardware output is the flop itself.
  if (WIDTH < 2) begin : g_bad_width
    $error("ttl_74198: WIDTH must be at least 2");
  end
  if (DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_bad_delay
    $error("ttl_74198: delays must be non-negative");
  end

  always_ff @(posedge Clk or negedge Clear_bar) begin
    if (!Clear_bar) begin
      q_current <= '0;
    end
`ifdef TTL_74198_CLK_INHIBIT_EN
    else if (Clk_inhibit) begin
      q_current <= q_current;
    end
`endif
    else begin
      // An unknown S falls to the default so bench errors show up as X on Q.
      case (shift_mode_e'(S))
        MODE_HOLD:        q_current <= q_current;
        MODE_SHIFT_RIGHT: q_current <= {q_current[WIDTH-2:0], DSR};
        MODE_SHIFT_LEFT:  q_current <= {DSL, q_current[WIDTH-1:1]};
        MODE_LOAD:        q_current <= D;
        default:          q_current <= 'x;
      endcase
    end
  end

  assign Q = q_current;

endmodule

// File: tb/tb_ttl_74198.sv
// Scoreboard bench for ttl_74198: driver pushes hand-computed Q values, monitor pops and compares.
module tb_ttl_74198;

  logic       Clk = 1'b0;
  logic       Clear_bar;
  logic [1:0] S;
  logic       DSR;
  logic       DSL;
  logic [7:0] D;
  logic [7:0] Q;
`ifdef TTL_74198_CLK_INHIBIT_EN
  logic       Clk_inhibit;
`endif

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  string      name_q[$];
  event       mon_ev;

  ttl_74198 #(.WIDTH(8), .DELAY_RISE(0), .DELAY_FALL(0)) dut (
    .Clk        (Clk),
`ifdef TTL_74198_CLK_INHIBIT_EN
    .Clk_inhibit(Clk_inhibit),
`endif
    .Clear_bar  (Clear_bar),
    .S          (S),
    .DSR        (DSR),
    .DSL        (DSL),
    .D          (D),
    .Q          (Q)
  );

  always #5 Clk = ~Clk;

  // Monitor: compares everything queued, on each falling edge or on demand.
  initial begin
    forever begin
      @(negedge Clk or mon_ev);
      while (exp_q.size() > 0) begin
        logic [7:0] e;
        string      n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        total++;
        if (Q !== e) begin
          bad++;
          $display("FAIL %s: Q=%h expected %h", n, Q, e);
        end
      end
    end
  end

  task automatic expect_q(input logic [7:0] e, input string n);
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  task automatic sample_now();
    -> mon_ev;
    #1;
  endtask

  // Drive one set of inputs for the next rising edge, then queue the value Q must hold after it.
  task automatic step(input logic clr_n, input logic [1:0] s, input logic [7:0] d,
                      input logic dsr, input logic dsl, input logic [7:0] e, input string n);
    @(negedge Clk);
    #1;
    Clear_bar = clr_n;
    S   = s;
    D   = d;
    DSR = dsr;
    DSL = dsl;
    @(posedge Clk);
    #1;
    expect_q(e, n);
  endtask

  logic [7:0] sr_exp [8] = '{8'h01, 8'h02, 8'h05, 8'h0B, 8'h16, 8'h2C, 8'h59, 8'hB2};
  logic       sr_bits[8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [7:0] sl_exp [8] = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

  initial begin
    Clear_bar = 1'b0;
    S   = 2'b11;
    D   = 8'hFF;
    DSR = 1'b1;
    DSL = 1'b1;
`ifdef TTL_74198_CLK_INHIBIT_EN
    Clk_inhibit = 1'b0;
`endif
    repeat (2) @(posedge Clk);
    #1;
    expect_q(8'h00, "reset_state");

    // Clear pulse between edges, then edges ignored while clear is held
    step(1'b1, 2'b11, 8'hA5, 1'b0, 1'b0, 8'hA5, "load_a5");
    sample_now();
    Clear_bar = 1'b0;
    #1;
    expect_q(8'h00, "clear_async");
    sample_now();
    step(1'b0, 2'b11, 8'hFF, 1'b1, 1'b1, 8'h00, "clear_held_load");
    step(1'b0, 2'b01, 8'hFF, 1'b1, 1'b1, 8'h00, "clear_held_shift");

    // First edge after release acts normally, then hold ignores D
    step(1'b1, 2'b11, 8'h3C, 1'b0, 1'b0, 8'h3C, "load_3c");
    for (int i = 0; i < 3; i++) step(1'b1, 2'b00, 8'hFF, 1'b1, 1'b1, 8'h3C, "hold");

    // Clear falling together with a load edge: clear wins
    @(negedge Clk);
    #1;
    S = 2'b11;
    D = 8'hFF;
    @(posedge Clk);
    Clear_bar = 1'b0;
    #1;
    expect_q(8'h00, "clear_vs_edge");

    // Shift-right fill: first bit ends at Q[7]
    for (int i = 0; i < 8; i++) step(1'b1, 2'b01, 8'h00, sr_bits[i], 1'b0, sr_exp[i], "shift_right_fill");

    step(1'b1, 2'b11, 8'h00, 1'b0, 1'b0, 8'h00, "load_zero");
    // Shift-left fill: first bit ends at Q[0]
    for (int i = 0; i < 8; i++) step(1'b1, 2'b10, 8'hFF, 1'b0, (i == 0), sl_exp[i], "shift_left_fill");

    // End bits discarded in both directions
    step(1'b1, 2'b11, 8'h81, 1'b0, 1'b0, 8'h81, "load_81");
    step(1'b1, 2'b01, 8'hFF, 1'b0, 1'b0, 8'h02, "shr_discard");
    step(1'b1, 2'b10, 8'hFF, 1'b0, 1'b1, 8'h81, "shl_discard");

    // Reset mid-shift loses the partial word
    step(1'b1, 2'b01, 8'h00, 1'b1, 1'b0, 8'h03, "shr_partial1");
    step(1'b1, 2'b01, 8'h00, 1'b1, 1'b0, 8'h07, "shr_partial2");
    sample_now();
    Clear_bar = 1'b0;
    #1;
    expect_q(8'h00, "clear_mid_shift");
    sample_now();

`ifdef TTL_74198_CLK_INHIBIT_EN
    step(1'b1, 2'b11, 8'h3C, 1'b0, 1'b0, 8'h3C, "inh_load");
    Clk_inhibit = 1'b1;
    step(1'b1, 2'b11, 8'h00, 1'b0, 1'b0, 8'h3C, "inh_blocks_load");
    step(1'b1, 2'b01, 8'h00, 1'b1, 1'b0, 8'h3C, "inh_blocks_shift");
    Clk_inhibit = 1'b0;
    step(1'b1, 2'b11, 8'h00, 1'b0, 1'b0, 8'h00, "inh_released");
    step(1'b1, 2'b11, 8'h3C, 1'b0, 1'b0, 8'h3C, "inh_reload");
    Clk_inhibit = 1'b1;
    sample_now();
    Clear_bar = 1'b0;
    #1;
    expect_q(8'h00, "inh_clear");
    sample_now();
    Clk_inhibit = 1'b0;
`endif

    repeat (4) @(negedge Clk);
    #1;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: pending=%0d expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: time=%0t limit 50000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
